uart_rx_words: RTL and testbench

UART_RX_WORDS -- requirements
Module: uart_rx_words

---
 rtl/uart_rx_words.sv | 159 +++++++++++++++
 tb/tb_uart_rx_words.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_words.sv
// uart_rx_words: 8N1 UART receiver that packs four bytes (little-endian)
// into 32-bit words and numbers them 0..NUM_WORDS-1 within a frame.
// A partial word is dropped on a framing error or after 16 idle bit periods.
module uart_rx_words #(
   parameter int DELAY_FRAMES = 234,
   parameter int NUM_WORDS    = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_rx,
   output logic [31:0] word_data,
   output logic [6:0]  word_index,
   output logic        word_valid,
   output logic        frame_done,
   output logic        frame_error
);

   localparam int BIT_T = DELAY_FRAMES + 1;
   localparam int HALF  = BIT_T / 2;
   localparam int TMO   = 16 * BIT_T;
   localparam int CW    = $clog2(BIT_T + 1);
   localparam int TW    = $clog2(TMO + 1);

   localparam logic [CW-1:0] C_BIT_LAST  = CW'(BIT_T - 1);
   localparam logic [CW-1:0] C_HALF_LAST = CW'(HALF - 1);
   localparam logic [TW-1:0] C_TMO_LAST  = TW'(TMO - 1);
   localparam logic [6:0]    C_IDX_LAST  = 7'(NUM_WORDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t        r_state;
   logic          r_sync1, r_sync2;
   logic [CW-1:0] r_cnt;
   logic [TW-1:0] r_tmo;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic [1:0]    r_byte_cnt;
   logic [23:0]   r_part;
   logic [6:0]    r_next_idx;
   logic          r_armed;     // line seen high since reset / last framing error
   logic [31:0]   r_word_data;
   logic [6:0]    r_word_index;
   logic          r_word_valid, r_frame_done, r_frame_error;
   logic          w_rx;

   assign w_rx        = r_sync2;
   assign word_data   = r_word_data;
   assign word_index  = r_word_index;
   assign word_valid  = r_word_valid;
   assign frame_done  = r_frame_done;
   assign frame_error = r_frame_error;

   // two-flop synchronizer for the asynchronous serial line, idles high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= uart_rx;
         r_sync2 <= r_sync1;
      end
   end

   // receiver FSM, byte packing, word numbering and idle resync timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_tmo         <= '0;
         r_bit_idx     <= '0;
         r_shift       <= '0;
         r_byte_cnt    <= '0;
         r_part        <= '0;
         r_next_idx    <= '0;
         r_armed       <= 1'b0;
         r_word_data   <= '0;
         r_word_index  <= '0;
         r_word_valid  <= 1'b0;
         r_frame_done  <= 1'b0;
         r_frame_error <= 1'b0;
      end else begin
         r_word_valid  <= 1'b0;
         r_frame_done  <= 1'b0;
         r_frame_error <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!w_rx && r_armed) begin
                  r_state <= S_START;
                  r_cnt   <= '0;
                  r_tmo   <= '0;
               end else begin
                  if (w_rx) r_armed <= 1'b1;
                  // partial word waiting too long: drop it quietly
                  if (r_byte_cnt != 2'd0) begin
                     if (r_tmo == C_TMO_LAST) begin
                        r_byte_cnt <= '0;
                        r_tmo      <= '0;
                     end else begin
                        r_tmo <= r_tmo + 1'b1;
                     end
                  end
               end
            end
            S_START: begin
               if (r_cnt == C_HALF_LAST) begin
                  r_cnt <= '0;
                  if (w_rx) begin
                     r_state <= S_IDLE;          // glitch, not a real start bit
                  end else begin
                     r_state   <= S_DATA;
                     r_bit_idx <= '0;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (r_cnt == C_BIT_LAST) begin
                  r_cnt     <= '0;
                  r_shift   <= {w_rx, r_shift[7:1]};   // LSB arrives first
                  r_bit_idx <= r_bit_idx + 1'b1;
                  if (r_bit_idx == 3'd7) r_state <= S_STOP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (r_cnt == C_BIT_LAST) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
                  r_armed <= w_rx;              // low stop: wait for line high again
                  if (w_rx) begin
                     case (r_byte_cnt)
                        2'd0: r_part[7:0]   <= r_shift;
                        2'd1: r_part[15:8]  <= r_shift;
                        2'd2: r_part[23:16] <= r_shift;
                        default: begin
                           r_word_data  <= {r_shift, r_part};
                           r_word_index <= r_next_idx;
                           r_word_valid <= 1'b1;
                           r_frame_done <= (r_next_idx == C_IDX_LAST);
                           r_next_idx   <= (r_next_idx == C_IDX_LAST) ? 7'd0 : r_next_idx + 7'd1;
                        end
                     endcase
                     r_byte_cnt <= r_byte_cnt + 2'd1;   // 3 wraps to 0
                  end else begin
                     r_frame_error <= 1'b1;
                     r_byte_cnt    <= '0;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_words.sv
// tb_uart_rx_words: drives 8N1 bytes (directed and $urandom) into the
// receiver and compares words/pulses against a queue-based byte model.
module tb_uart_rx_words;

   localparam int DF  = 15;
   localparam int NW  = 4;
   localparam int BIT = DF + 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        uart_rx = 1'b1;
   logic [31:0] word_data;
   logic [6:0]  word_index;
   logic        word_valid, frame_done, frame_error;

   uart_rx_words #(.DELAY_FRAMES(DF), .NUM_WORDS(NW)) dut (
      .clk         (clk),
      .rst         (rst),
      .uart_rx     (uart_rx),
      .word_data   (word_data),
      .word_index  (word_index),
      .word_valid  (word_valid),
      .frame_done  (frame_done),
      .frame_error (frame_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic [6:0]  idx;
      logic        done;
   } exp_t;

   int          n_cmp = 0;
   int          n_mis = 0;
   exp_t        exp_q[$];
   byte unsigned m_bytes[$];
   int          m_idx  = 0;
   int          m_ferr = 0;
   int          o_ferr = 0;
   logic        prev_v = 1'b0, prev_e = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // reference: good bytes accumulate, every 4th makes a numbered word
   task automatic model_byte(input byte unsigned b, input bit ok);
      exp_t e;
      if (ok) begin
         m_bytes.push_back(b);
         if (m_bytes.size() == 4) begin
            e.d    = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
            e.idx  = 7'(m_idx);
            e.done = (m_idx == NW - 1);
            exp_q.push_back(e);
            m_idx = (m_idx + 1) % NW;
            m_bytes.delete();
         end
      end else begin
         m_bytes.delete();
         m_ferr++;
      end
   endtask

   task automatic model_reset();
      m_bytes.delete();
      m_idx = 0;
   endtask

   task automatic send_byte(input byte unsigned b, input bit ok);
      model_byte(b, ok);
      uart_rx = 1'b0;
      repeat (BIT) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (BIT) @(posedge clk);
      end
      uart_rx = ok;
      repeat (BIT) @(posedge clk);
      uart_rx = 1'b1;
      if (!ok) repeat (BIT) @(posedge clk);
   endtask

   task automatic idle_bits(input int n);
      if (n >= 17) m_bytes.delete();
      uart_rx = 1'b1;
      repeat (n * BIT) @(posedge clk);
   endtask

   task automatic settle(input string tag);
      idle_bits(3);
      chk({tag, "_missing_words"}, exp_q.size(), 0);
      chk({tag, "_ferr_count"}, o_ferr, m_ferr);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_data"},  word_data,   0);
      chk({tag, "_index"}, word_index,  0);
      chk({tag, "_valid"}, word_valid,  0);
      chk({tag, "_done"},  frame_done,  0);
      chk({tag, "_err"},   frame_error, 0);
   endtask

   // output monitor: every pulse must match the model
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (word_valid) begin
            if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("word_data",  word_data,  e.d);
               chk("word_index", word_index, e.idx);
               chk("frame_done", frame_done, e.done);
            end
         end else if (frame_done) begin
            chk("done_without_valid", frame_done, 0);
         end
         if (frame_error) begin
            o_ferr++;
            chk("err_with_valid", word_valid, 0);
         end
         if (prev_v && word_valid)  chk("valid_two_cycles", 1, 0);
         if (prev_e && frame_error) chk("err_two_cycles", 1, 0);
         prev_v = word_valid;
         prev_e = frame_error;
      end else begin
         prev_v = 1'b0;
         prev_e = 1'b0;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      byte unsigned b;
      int g;

      // reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk_zero("reset");
      @(posedge clk);
      rst = 1'b0;
      idle_bits(2);

      // basic little-endian word
      send_byte(8'h78, 1'b1);
      send_byte(8'h56, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'h12, 1'b1);
      settle("basic");
      chk("basic_word", word_data, 32'h12345678);
      chk("basic_index", word_index, 0);

      // index walk and wrap: 16 bytes -> idx 1,2,3,0
      for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b1);
      settle("wrap");
      chk("wrap_index", word_index, 0);

      // short low glitch on idle line, then a byte still received
      uart_rx = 1'b0;
      repeat (BIT / 4) @(posedge clk);
      idle_bits(2);
      for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
      settle("glitch");

      // framing error then 4 good bytes at unchanged index
      send_byte(8'hAA, 1'b0);
      idle_bits(1);
      for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
      settle("ferr");

      // idle resync drops a 2-byte partial word
      send_byte(8'hEE, 1'b1);
      send_byte(8'hDD, 1'b1);
      idle_bits(20);
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h03, 1'b1);
      send_byte(8'h04, 1'b1);
      settle("resync");
      chk("resync_word", word_data, 32'h04030201);

      // random mix of bytes, gaps, framing errors, long idles
      for (int i = 0; i < 40; i++) begin
         b = 8'($urandom);
         send_byte(b, ($urandom_range(7) != 0));
         g = ($urandom_range(9) == 0) ? 20 : $urandom_range(3);
         idle_bits(g);
      end
      settle("random");

      // reset in bit 4 of the 3rd byte of word 5
      rst = 1'b1;
      repeat (2) @(posedge clk);
      rst = 1'b0;
      model_reset();
      idle_bits(2);
      for (int i = 0; i < 22; i++) send_byte(8'($urandom), 1'b1);
      b = 8'($urandom);
      uart_rx = 1'b0;
      repeat (BIT) @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         uart_rx = b[i];
         repeat (BIT) @(posedge clk);
      end
      uart_rx = b[4];
      repeat (BIT / 2) @(posedge clk);
      #3 rst = 1'b1;
      #1 chk_zero("midreset");
      model_reset();
      chk("midreset_pending", exp_q.size(), 0);
      uart_rx = 1'b1;
      repeat (3) @(posedge clk);
      rst = 1'b0;
      idle_bits(2);
      for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
      settle("postreset");
      chk("postreset_index", word_index, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
